// File: rtl/alu_pkg.sv
// Shared definitions for the add_sub result buffer: OP codes, result width and entry layout.
// Optional consistency checking elsewhere is enabled by defining ALU_RES_CHECK_EN.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned RES_W   = 4;
  localparam int unsigned ENTRY_W = 8;

  // Entry layout: {op, r[3:0], sf, zf, dzf}
  localparam int unsigned ENT_DZF   = 0;
  localparam int unsigned ENT_ZF    = 1;
  localparam int unsigned ENT_SF    = 2;
  localparam int unsigned ENT_R_LSB = 3;
  localparam int unsigned ENT_R_MSB = ENT_R_LSB + RES_W - 1;
  localparam int unsigned ENT_OP    = 7;

  typedef struct packed {
    logic             op;
    logic [RES_W-1:0] r;
    logic             sf;
    logic             zf;
    logic             dzf;
  } alu_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic             op,
                                                    input logic [RES_W-1:0] r,
                                                    input logic             sf,
                                                    input logic             zf,
                                                    input logic             dzf);
    logic [ENTRY_W-1:0] e;
    e                       = '0;
    e[ENT_OP]               = op;
    e[ENT_R_MSB:ENT_R_LSB]  = r;
    e[ENT_SF]               = sf;
    e[ENT_ZF]               = zf;
    e[ENT_DZF]              = dzf;
    return e;
  endfunction

  function automatic alu_entry_t unpack_entry(input logic [ENTRY_W-1:0] e);
    alu_entry_t s;
    s.op  = e[ENT_OP];
    s.r   = e[ENT_R_MSB:ENT_R_LSB];
    s.sf  = e[ENT_SF];
    s.zf  = e[ENT_ZF];
    s.dzf = e[ENT_DZF];
    return s;
  endfunction

endpackage

// File: rtl/alu_sticky_status.sv
// Sticky SF/ZF/DZF flags and saturating accepted-result counter for the ALU result FIFO.
// Defining ALU_RES_CHECK_EN adds chk_err, a sticky flag/result consistency error.
module alu_sticky_status
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             clr,
`ifdef ALU_RES_CHECK_EN
  input  logic [RES_W-1:0] in_r,
`endif
  input  logic             in_sf,
  input  logic             in_zf,
  input  logic             in_dzf,
  output logic             sticky_sf,
  output logic             sticky_zf,
  output logic             sticky_dzf,
`ifdef ALU_RES_CHECK_EN
  output logic             chk_err,
`endif
  output logic [CNT_W-1:0] result_cnt
);

  logic [2:0]       sticky_q, sticky_d;
  logic [2:0]       in_flags;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_flags = {in_sf, in_zf, in_dzf};

  // A clear coinciding with a push keeps only the pushed entry's contribution.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr) begin
      sticky_d = push ? in_flags : 3'b000;
      cnt_d    = push ? CNT_W'(1) : '0;
    end else if (push) begin
      sticky_d = sticky_q | in_flags;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 3'b000;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_sf  = sticky_q[2];
  assign sticky_zf  = sticky_q[1];
  assign sticky_dzf = sticky_q[0];
  assign result_cnt = cnt_q;

`ifdef ALU_RES_CHECK_EN
  logic chk_q, chk_d, mismatch;

  // Sign-magnitude: SF must mirror the sign bit, ZF must flag a zero magnitude (incl. -0).
  assign mismatch = (in_sf != in_r[RES_W-1]) ||
                    (in_zf != (in_r[RES_W-2:0] == '0));

  always_comb begin
    chk_d = chk_q;
    if (clr) begin
      chk_d = push & mismatch;
    end else if (push) begin
      chk_d = chk_q | mismatch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk_err = chk_q;
`endif

endmodule

// File: rtl/alu_result_fifo.sv
// Valid/ready FIFO buffering add_sub results {op, r, sf, zf, dzf} plus sticky status.
// Defining ALU_RES_CHECK_EN adds the chk_err output.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_op,
  input  logic [RES_W-1:0]         in_r,
  input  logic                     in_sf,
  input  logic                     in_zf,
  input  logic                     in_dzf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_op,
  output logic [RES_W-1:0]         out_r,
  output logic                     out_sf,
  output logic                     out_zf,
  output logic                     out_dzf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_sf,
  output logic                     sticky_zf,
  output logic                     sticky_dzf,
  input  logic                     clr_sticky,
`ifdef ALU_RES_CHECK_EN
  output logic                     chk_err,
`endif
  output logic [CNT_W-1:0]         result_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               full, empty, push, pop;
  alu_entry_t         head;

  // MSB of each pointer is a wrap bit distinguishing full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; out_* are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= pack_entry(in_op, in_r, in_sf, in_zf, in_dzf);
    end
  end

  assign head    = unpack_entry(mem[rd_ptr_q[AW-1:0]]);
  assign out_op  = head.op;
  assign out_r   = head.r;
  assign out_sf  = head.sf;
  assign out_zf  = head.zf;
  assign out_dzf = head.dzf;

  assign count = wr_ptr_q - rd_ptr_q;

  alu_sticky_status #(
    .CNT_W (CNT_W)
  ) u_status (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .clr        (clr_sticky),
`ifdef ALU_RES_CHECK_EN
    .in_r       (in_r),
`endif
    .in_sf      (in_sf),
    .in_zf      (in_zf),
    .in_dzf     (in_dzf),
    .sticky_sf  (sticky_sf),
    .sticky_zf  (sticky_zf),
    .sticky_dzf (sticky_dzf),
`ifdef ALU_RES_CHECK_EN
    .chk_err    (chk_err),
`endif
    .result_cnt (result_cnt)
  );

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (default DEPTH=4 plus a CNT_W=3 instance).
// chk_err checks are included when ALU_RES_CHECK_EN is defined.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_checks = 0;
  int         n_errors = 0;

  // Main instance (DEPTH=4, CNT_W=8)
  logic       in_valid, in_ready, in_op, in_sf, in_zf, in_dzf;
  logic [3:0] in_r;
  logic       out_valid, out_ready, out_op, out_sf, out_zf, out_dzf;
  logic [3:0] out_r;
  logic [2:0] count;
  logic       sticky_sf, sticky_zf, sticky_dzf, clr_sticky;
  logic [7:0] result_cnt;

  // Saturation instance (DEPTH=4, CNT_W=3)
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic       s_out_op, s_out_sf, s_out_zf, s_out_dzf;
  logic [3:0] s_out_r;
  logic [2:0] s_count;
  logic       s_sticky_sf, s_sticky_zf, s_sticky_dzf;
  logic [2:0] s_result_cnt;

`ifdef ALU_RES_CHECK_EN
  logic       chk_err, s_chk_err;
`endif

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_r       (in_r),
    .in_sf      (in_sf),
    .in_zf      (in_zf),
    .in_dzf     (in_dzf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_r      (out_r),
    .out_sf     (out_sf),
    .out_zf     (out_zf),
    .out_dzf    (out_dzf),
    .count      (count),
    .sticky_sf  (sticky_sf),
    .sticky_zf  (sticky_zf),
    .sticky_dzf (sticky_dzf),
    .clr_sticky (clr_sticky),
`ifdef ALU_RES_CHECK_EN
    .chk_err    (chk_err),
`endif
    .result_cnt (result_cnt)
  );

  alu_result_fifo #(.DEPTH(4), .CNT_W(3)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_op      (1'b0),
    .in_r       (4'b0101),
    .in_sf      (1'b0),
    .in_zf      (1'b0),
    .in_dzf     (1'b0),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_op     (s_out_op),
    .out_r      (s_out_r),
    .out_sf     (s_out_sf),
    .out_zf     (s_out_zf),
    .out_dzf    (s_out_dzf),
    .count      (s_count),
    .sticky_sf  (s_sticky_sf),
    .sticky_zf  (s_sticky_zf),
    .sticky_dzf (s_sticky_dzf),
    .clr_sticky (1'b0),
`ifdef ALU_RES_CHECK_EN
    .chk_err    (s_chk_err),
`endif
    .result_cnt (s_result_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic op, input logic [3:0] r, input logic sf, input logic zf,
                      input logic dzf);
    in_valid = 1'b1;
    in_op    = op;
    in_r     = r;
    in_sf    = sf;
    in_zf    = zf;
    in_dzf   = dzf;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_r [4];
    exp_r[0] = 4'b0001; exp_r[1] = 4'b0010; exp_r[2] = 4'b0011; exp_r[3] = 4'b1001;

    rst_n = 1'b0;
    in_valid = 1'b0; in_op = 1'b0; in_r = 4'h0; in_sf = 1'b0; in_zf = 1'b0; in_dzf = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_result_cnt", result_cnt, 0);
    check("rst_sticky", {sticky_sf, sticky_zf, sticky_dzf}, 0);
`ifdef ALU_RES_CHECK_EN
    check("rst_chk_err", chk_err, 0);
`endif
    rst_n = 1'b1;
    step();

    // Single push, one-cycle latency, then pop.
    push(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_r", out_r, 4'b0110);
    check("t1_out_op", out_op, 0);
    check("t1_count", count, 1);
    check("t1_result_cnt", result_cnt, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_empty", out_valid, 0);
    check("t1_count0", count, 0);

    // Fill to full, overflow attempt ignored, drain in order.
    for (int i = 0; i < 4; i++) push(i[0], exp_r[i], exp_r[i][3], 1'b0, 1'b0);
    check("t2_count_full", count, 4);
    check("t2_in_ready_full", in_ready, 0);
    push(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    check("t2_count_ignored", count, 4);
    check("t2_result_cnt", result_cnt, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", out_valid, 1);
      check("t2_drain_r", out_r, exp_r[i]);
      check("t2_drain_op", out_op, i % 2);
      step();
      if (i == 0) check("t2_in_ready_after_pop", in_ready, 1);
    end
    out_ready = 1'b0;
    check("t2_empty", out_valid, 0);

    // Steady state at count=2 with simultaneous push/pop; pointers wrap.
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_r = 4'((i + 2) & 15);
      out_ready = 1'b1;
      #1;
      check("t3_count", count, 2);
      check("t3_head", out_r, i & 15);
      step();
    end
    in_valid = 1'b0;
    check("t3_head10", out_r, 10);
    step();
    out_ready = 1'b0;
    check("t3_head11", out_r, 11);
    check("t3_count1", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_empty", out_valid, 0);
    check("t3_result_cnt", result_cnt, 17);

    // Sticky flags and clear-with-push.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t4_clr_sticky", {sticky_sf, sticky_zf, sticky_dzf}, 0);
    check("t4_clr_cnt", result_cnt, 0);
    push(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("t4_sticky", {sticky_sf, sticky_zf, sticky_dzf}, 3'b110);
    check("t4_cnt2", result_cnt, 2);
    clr_sticky = 1'b1;
    push(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b0;
    check("t4_clr_push_sticky", {sticky_sf, sticky_zf, sticky_dzf}, 3'b001);
    check("t4_clr_push_cnt", result_cnt, 1);
    check("t4_count", count, 3);
    out_ready = 1'b1;
    check("t4_e0", {out_op, out_r, out_sf, out_zf, out_dzf}, 8'b1_1011_100);
    step();
    check("t4_e1", {out_op, out_r, out_sf, out_zf, out_dzf}, 8'b0_0000_010);
    step();
    check("t4_e2", {out_op, out_r, out_sf, out_zf, out_dzf}, 8'b1_0001_001);
    step();
    out_ready = 1'b0;
    check("t4_empty", out_valid, 0);
    check("t4_cnt_hold", result_cnt, 1);

`ifdef ALU_RES_CHECK_EN
    check("t6_chk_clean", chk_err, 0);
    push(1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
    check("t6_chk_sign", chk_err, 1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t6_chk_clr", chk_err, 0);
    push(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    check("t6_chk_zero", chk_err, 1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    push(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("t6_chk_ok", chk_err, 0);
`endif

    // Saturating counter on CNT_W=3 instance, then async reset mid-burst.
    s_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_in_valid = 1'b1;
      step();
      check("t5_sat_cnt", s_result_cnt, (i + 1 > 7) ? 7 : i + 1);
    end
    s_out_ready = 1'b0;
    step();
    step();
    check("t5_sat_hold", s_result_cnt, 7);
    check("t5_sat_count", s_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_arst_count", s_count, 0);
    check("t5_arst_valid", s_out_valid, 0);
    check("t5_arst_cnt", s_result_cnt, 0);
    check("t5_arst_main_count", count, 0);
    check("t5_arst_main_cnt", result_cnt, 0);
    s_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
